store_buffer_fwd: RTL
=====================

Name: store_buffer_fwd

Overview:
- Parametrised store buffer holding stores from dispatch through retirement to memory drain; successor to the fixed STORE_entry_t format.
- Adds configurable depth, ROB-ordered commit tracking, flush of speculative stores, byte-strobe drain, and store-to-load forwarding with partial-overlap stall.
- Sits between the LSU execute stage, the ROB commit port, and the data-memory write port.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width; only 32 is supported, so strobes are 4 bits.
- ROB_WIDTH, 5, ROB id width.
- AGE_WIDTH, 10, program-order age tag width; compares are modular.
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  dispatch allocates one store entry.
- alloc_rob_id  in  ROB_WIDTH  ROB id of the store.
- alloc_age  in  AGE_WIDTH  age tag of the store.
- alloc_ready  out  1  not full.
- alloc_idx  out  IDX_W  index that will be granted, equal to tail.
- exec_valid  in  1  address and data are resolved for one entry.
- exec_idx  in  IDX_W  entry being written.
- exec_addr  in  ADDR_WIDTH  store byte address.
- exec_data  in  DATA_WIDTH  store data, LSB-aligned.
- exec_funct3  in  3  0=SB, 1=SH, 2=SW.
- commit_valid  in  1  ROB retires the oldest uncommitted store.
- commit_rob_id  in  ROB_WIDTH  ROB id being retired, used for checking.
- flush  in  1  mispredict or exception; discard all uncommitted entries.
- mem_req_valid  out  1  drain request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH  word-aligned address, low two bits zero.
- mem_req_data  out  DATA_WIDTH  data shifted to byte lanes.
- mem_req_wstrb  out  4  byte strobes.
- ld_valid  in  1  load forwarding query.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_funct3  in  3  0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- ld_age  in  AGE_WIDTH  load age tag.
- fwd_hit  out  1  load is fully satisfied by a buffered store.
- fwd_data  out  DATA_WIDTH  extended load result.
- fwd_stall  out  1  load must replay.
- count  out  IDX_W+1  number of occupied entries.
- empty  out  1  count==0.
- commit_err  out  1  sticky protocol-error flag.

Behaviour:
- Entry fields: valid, executed, committed, rob_id, age, addr, data, wstrb.
- Pointers: head (oldest, drain point), cptr (oldest uncommitted), tail (next free). All are IDX_W wide and wrap modulo DEPTH.
- Reset, asynchronous: all entries invalid; head=cptr=tail=0; count=0; empty=1; alloc_ready=1; mem_req_valid=0; fwd_hit=0; fwd_stall=0; fwd_data=0; commit_err=0. All other outputs are 0.
- Alloc:
  - Fires on alloc_valid && alloc_ready.
  - Writes rob_id and age at tail, sets valid, clears executed and committed, then tail++.
  - When full, alloc_valid is ignored and state is unchanged.
- Exec:
  - Writes addr, data and executed into exec_idx.
  - wstrb is computed from funct3 and addr[1:0]: SB gives 1<<a, SH gives 3<<a, SW gives 4'hF.
  - Misaligned SH/SW, or exec to an invalid entry: the write is ignored and commit_err is set.
- Commit:
  - Fires when commit_valid is high and entry[cptr] is valid, executed and not committed. It sets committed and does cptr++.
  - If commit_rob_id ≠ entry[cptr].rob_id, or the entry is not executed, or no uncommitted entry exists: no state change and commit_err is set.
- Drain:
  - mem_req_valid = entry[head].valid && committed. The request is derived from registered state, so a store committed at edge N is requested from cycle N+1 onward.
  - When mem_req_valid && mem_req_ready at an edge: invalidate head, head++.
  - The request must stay stable while mem_req_ready is low.
- Flush:
  - Invalidates every entry that is not committed, and sets tail=cptr.
  - Committed entries keep draining.
- Simultaneous events in one cycle, in priority order:
  - Commit is evaluated before flush, so the store committed that cycle survives.
  - Flush beats alloc; the allocation is dropped.
  - Alloc and drain together leave count unchanged.
  - Exec is ignored for entries flushed that cycle.
- count = number of valid entries, 0..DEPTH. Full ⇔ count==DEPTH, and alloc_ready=!full.
- Forwarding is combinational, zero latency, and only evaluated when ld_valid=1; otherwise fwd_hit=0, fwd_stall=0, fwd_data=0.
  - Older test: an entry is older if d=(ld_age−e.age) mod 2^AGE_WIDTH satisfies d≠0 and d[MSB]=0.
  - Load mask: built from ld_funct3 and ld_addr[1:0] the same way as stores.
  - Candidates: valid, older entries. An unexecuted candidate forces fwd_stall=1.
  - Otherwise select the youngest executed candidate with the same word address and a nonzero mask overlap.
  - If that candidate's wstrb covers the load mask: fwd_hit=1. fwd_data takes the selected lanes shifted down and sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Partial overlap: fwd_stall=1 and fwd_hit=0.
  - fwd_stall dominates fwd_hit.
  - No candidate: both are 0.
- Reset asserted mid-operation clears everything immediately; an in-flight mem request is dropped.

Test Plan:
- Reset, alloc 8 stores (DEPTH=8) → count=8, alloc_ready=0. A 9th alloc is ignored and tail is unchanged.
- SW 0x100=0xDEADBEEF committed with mem_req_ready=0 for 3 cycles → request held stable. On ready=1 the request carries addr 0x100, wstrb 4'hF, data 0xDEADBEEF; count decrements.
- SB 0x201=0x80 executed (age 5), then LB 0x201 with age 6 → fwd_hit=1 and fwd_data=0xFFFFFF80. LBU gives 0x00000080. A load with age 4 gives no hit.
- SB 0x300=0x11, then LW 0x300 younger → fwd_stall=1 and fwd_hit=0. An unexecuted older store gives fwd_stall=1.
- Alloc A, B, C; commit A; flush and alloc in the same cycle → only A remains (count=1), tail=cptr, and A still drains.
- Commit with a wrong rob_id → no state change and commit_err=1 (sticky). Age wrap: store age 1023, load age 2 → treated as older and forwards.

Source files
------------

// File: rtl/store_buffer_fwd.sv
// Store buffer: holds stores from dispatch through ROB commit to memory drain,
// with flush of speculative entries and store-to-load forwarding.
module store_buffer_fwd #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5,
    parameter int AGE_WIDTH  = 10,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [ROB_WIDTH-1:0]  alloc_rob_id,
    input  logic [AGE_WIDTH-1:0]  alloc_age,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_idx,
    input  logic                  exec_valid,
    input  logic [IDX_W-1:0]      exec_idx,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_data,
    input  logic [2:0]            exec_funct3,
    input  logic                  commit_valid,
    input  logic [ROB_WIDTH-1:0]  commit_rob_id,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    input  logic [AGE_WIDTH-1:0]  ld_age,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic [IDX_W:0]        count,
    output logic                  empty,
    output logic                  commit_err
);

    localparam int CNT_W = IDX_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;

    logic [DEPTH-1:0]      e_valid, e_exec, e_cmt;
    logic [ROB_WIDTH-1:0]  e_rob   [DEPTH];
    logic [AGE_WIDTH-1:0]  e_age   [DEPTH];
    logic [WA_W-1:0]       e_waddr [DEPTH];
    logic [DATA_WIDTH-1:0] e_data  [DEPTH];
    logic [3:0]            e_strb  [DEPTH];
    logic [IDX_W-1:0]      head, cptr, tail;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd0:    return 4'(4'b0001 << a);
            2'd1:    return 4'(4'b0011 << a);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic store_bad(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return a != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    // Modular age compare: entry is older when ld_age - e_age is nonzero and "positive".
    function automatic logic is_older(input logic [AGE_WIDTH-1:0] la, input logic [AGE_WIDTH-1:0] ea);
        logic [AGE_WIDTH-1:0] d;
        d = la - ea;
        return (d != '0) && !d[AGE_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [2:0] f3,
                                                          input logic [DATA_WIDTH-1:0] sel);
        case (f3)
            3'd0:    return {{(DATA_WIDTH-8){sel[7]}}, sel[7:0]};
            3'd1:    return {{(DATA_WIDTH-16){sel[15]}}, sel[15:0]};
            3'd4:    return {{(DATA_WIDTH-8){1'b0}}, sel[7:0]};
            3'd5:    return {{(DATA_WIDTH-16){1'b0}}, sel[15:0]};
            default: return sel;
        endcase
    endfunction

    logic full, alloc_fire, drain_fire, commit_ok, commit_fire, commit_bad;
    logic exec_cmt_after, exec_flushed, exec_write, exec_err;
    logic [IDX_W-1:0] cptr_nxt;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(e_valid[i]);
    end

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_idx   = tail;

    assign mem_req_valid = e_valid[head] && e_cmt[head];
    assign mem_req_addr  = mem_req_valid ? {e_waddr[head], 2'b00} : '0;
    assign mem_req_data  = mem_req_valid ? e_data[head] : '0;
    assign mem_req_wstrb = mem_req_valid ? e_strb[head] : '0;

    assign alloc_fire  = alloc_valid && !full && !flush;
    assign drain_fire  = mem_req_valid && mem_req_ready;
    assign commit_ok   = e_valid[cptr] && e_exec[cptr] && !e_cmt[cptr] && (e_rob[cptr] == commit_rob_id);
    assign commit_fire = commit_valid && commit_ok;
    assign commit_bad  = commit_valid && !commit_ok;
    assign cptr_nxt    = commit_fire ? cptr + 1'b1 : cptr;

    // A store committed this cycle survives a simultaneous flush, so exec to it still lands.
    assign exec_cmt_after = e_cmt[exec_idx] || (commit_fire && (exec_idx == cptr));
    assign exec_flushed   = flush && e_valid[exec_idx] && !exec_cmt_after;
    assign exec_err       = exec_valid && !exec_flushed &&
                            (!e_valid[exec_idx] || store_bad(exec_funct3, exec_addr[1:0]));
    assign exec_write     = exec_valid && !exec_flushed && e_valid[exec_idx] &&
                            !store_bad(exec_funct3, exec_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid    <= '0;
            e_exec     <= '0;
            e_cmt      <= '0;
            head       <= '0;
            cptr       <= '0;
            tail       <= '0;
            commit_err <= 1'b0;
        end else begin
            if (alloc_fire) begin
                e_valid[tail] <= 1'b1;
                e_exec[tail]  <= 1'b0;
                e_cmt[tail]   <= 1'b0;
                tail          <= tail + 1'b1;
            end
            if (exec_write) e_exec[exec_idx] <= 1'b1;
            if (commit_fire) begin
                e_cmt[cptr] <= 1'b1;
                cptr        <= cptr_nxt;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!e_cmt[i] && !(commit_fire && (cptr == IDX_W'(i)))) begin
                        e_valid[i] <= 1'b0;
                        e_exec[i]  <= 1'b0;
                    end
                end
                tail <= cptr_nxt;
            end
            if (drain_fire) begin
                e_valid[head] <= 1'b0;
                e_exec[head]  <= 1'b0;
                e_cmt[head]   <= 1'b0;
                head          <= head + 1'b1;
            end
            if (commit_bad || exec_err) commit_err <= 1'b1;
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            e_rob[tail] <= alloc_rob_id;
            e_age[tail] <= alloc_age;
        end
        if (exec_write) begin
            e_waddr[exec_idx] <= exec_addr[ADDR_WIDTH-1:2];
            e_data[exec_idx]  <= DATA_WIDTH'(exec_data << {exec_addr[1:0], 3'b000});
            e_strb[exec_idx]  <= byte_mask(exec_funct3, exec_addr[1:0]);
        end
    end

    logic [3:0]       ld_mask;
    logic [IDX_W-1:0] idx, sel_idx;
    logic             found, any_unexec;

    // Walk from head so later matches are younger in program order.
    always_comb begin
        fwd_hit    = 1'b0;
        fwd_stall  = 1'b0;
        fwd_data   = '0;
        found      = 1'b0;
        any_unexec = 1'b0;
        sel_idx    = '0;
        idx        = '0;
        ld_mask    = byte_mask(ld_funct3, ld_addr[1:0]);
        if (ld_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + IDX_W'(i);
                if (e_valid[idx] && is_older(ld_age, e_age[idx])) begin
                    if (!e_exec[idx]) begin
                        any_unexec = 1'b1;
                    end else if ((e_waddr[idx] == ld_addr[ADDR_WIDTH-1:2]) &&
                                 ((e_strb[idx] & ld_mask) != 4'h0)) begin
                        found   = 1'b1;
                        sel_idx = idx;
                    end
                end
            end
            if (any_unexec) begin
                fwd_stall = 1'b1;
            end else if (found) begin
                if ((e_strb[sel_idx] & ld_mask) == ld_mask) begin
                    fwd_hit  = 1'b1;
                    fwd_data = extend_load(ld_funct3, e_data[sel_idx] >> {ld_addr[1:0], 3'b000});
                end else begin
                    fwd_stall = 1'b1;
                end
            end
        end
    end

endmodule
